// File: rtl/multi_rate_trigger_gen.sv
// multi_rate_trigger_gen
//   Multi-channel programmable rate generator. Each channel runs a free
//   counter over a runtime-writable period and produces a registered
//   ~50% duty square wave plus a REQ/ACK packet request. A request that is
//   still pending when the next one arrives is coalesced and flagged as a
//   sticky overrun.
//   Optional feature macro: TRIG_OVR_CNT_EN adds the OVR_CNT port with a
//   saturating 8-bit overrun event counter per channel.
module multi_rate_trigger_gen #(
  parameter int NUM_CH         = 4,
  parameter int CNT_WIDTH      = 25,
  parameter int DEFAULT_PERIOD = 10000000
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NUM_CH-1:0]      EN,
  input  logic                   CFG_WE,
  input  logic [3:0]             CFG_CH,
  input  logic [CNT_WIDTH-1:0]   CFG_PERIOD,
  input  logic [NUM_CH-1:0]      ACK,
  input  logic [NUM_CH-1:0]      OVR_CLR,
  output logic [NUM_CH-1:0]      TRIG_LVL,
  output logic [NUM_CH-1:0]      REQ,
`ifdef TRIG_OVR_CNT_EN
  output logic [NUM_CH-1:0]      OVR,
  output logic [8*NUM_CH-1:0]    OVR_CNT
`else
  output logic [NUM_CH-1:0]      OVR
`endif
);

  localparam logic [CNT_WIDTH-1:0] DEF_PER = CNT_WIDTH'(DEFAULT_PERIOD);
  localparam logic [CNT_WIDTH-1:0] MIN_PER = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_CH];
  logic [CNT_WIDTH-1:0] per_q [NUM_CH];
  logic [CNT_WIDTH-1:0] per_d [NUM_CH];
  logic [NUM_CH-1:0]    trig_lvl_q, trig_lvl_d;
  logic [NUM_CH-1:0]    req_q, req_d;
  logic [NUM_CH-1:0]    ovr_q, ovr_d;
  logic [NUM_CH-1:0]    wr_s, tick_s, ovr_evt_s;
  logic [CNT_WIDTH-1:0] cfg_per_s;
`ifdef TRIG_OVR_CNT_EN
  logic [7:0]           ovr_cnt_q [NUM_CH];
  logic [7:0]           ovr_cnt_d [NUM_CH];
`endif

  // Decode config writes, wrap ticks and overrun events per channel
  always_comb begin
    // Periods below 2 cannot produce a square wave, so clamp them up
    if (CFG_PERIOD < MIN_PER) begin
      cfg_per_s = MIN_PER;
    end else begin
      cfg_per_s = CFG_PERIOD;
    end
    wr_s      = '0;
    tick_s    = '0;
    ovr_evt_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      // CFG_CH values at or above NUM_CH never match a channel
      wr_s[c]      = CFG_WE && (CFG_CH == 4'(c));
      // A write in the wrap cycle restarts the channel and eats the tick
      tick_s[c]    = EN[c] && (cnt_q[c] == per_q[c] - ONE) && !wr_s[c];
      ovr_evt_s[c] = tick_s[c] && req_q[c] && !ACK[c];
    end
  end

  // Next-state for counters, periods, square wave, request and overrun flag
  always_comb begin
    trig_lvl_d = '0;
    req_d      = req_q;
    ovr_d      = ovr_q;
    for (int c = 0; c < NUM_CH; c++) begin
      per_d[c] = per_q[c];
      cnt_d[c] = cnt_q[c];
      if (wr_s[c]) begin
        per_d[c] = cfg_per_s;
        cnt_d[c] = '0;
      end else if (!EN[c]) begin
        cnt_d[c] = '0;
      end else if (cnt_q[c] >= per_q[c] - ONE) begin
        // >= also recovers a counter that somehow ran past its period
        cnt_d[c] = '0;
      end else begin
        cnt_d[c] = cnt_q[c] + ONE;
      end

      trig_lvl_d[c] = EN[c] && (cnt_q[c] < (per_q[c] >> 1));

      // A new tick re-arms REQ even if the old one is acked this cycle
      if (tick_s[c]) begin
        req_d[c] = 1'b1;
      end else if (ACK[c]) begin
        req_d[c] = 1'b0;
      end else begin
        req_d[c] = req_q[c];
      end

      // Setting an overrun has priority over clearing it
      if (ovr_evt_s[c]) begin
        ovr_d[c] = 1'b1;
      end else if (OVR_CLR[c]) begin
        ovr_d[c] = 1'b0;
      end else begin
        ovr_d[c] = ovr_q[c];
      end
    end
  end

`ifdef TRIG_OVR_CNT_EN
  // Saturating overrun event counters; clear together with an event gives 1
  always_comb begin
    OVR_CNT = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (OVR_CLR[c]) begin
        ovr_cnt_d[c] = ovr_evt_s[c] ? 8'd1 : 8'd0;
      end else if (ovr_evt_s[c] && (ovr_cnt_q[c] != 8'd255)) begin
        ovr_cnt_d[c] = ovr_cnt_q[c] + 8'd1;
      end else begin
        ovr_cnt_d[c] = ovr_cnt_q[c];
      end
      OVR_CNT[8*c +: 8] = ovr_cnt_q[c];
    end
  end

  // Overrun counter registers
  always_ff @(posedge CLK) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (RESET) begin
        ovr_cnt_q[c] <= 8'd0;
      end else begin
        ovr_cnt_q[c] <= ovr_cnt_d[c];
      end
    end
  end
`endif

  // Channel state registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      trig_lvl_q <= '0;
      req_q      <= '0;
      ovr_q      <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= '0;
        per_q[c] <= DEF_PER;
      end
    end else begin
      trig_lvl_q <= trig_lvl_d;
      req_q      <= req_d;
      ovr_q      <= ovr_d;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= cnt_d[c];
        per_q[c] <= per_d[c];
      end
    end
  end

  assign TRIG_LVL = trig_lvl_q;
  assign REQ      = req_q;
  assign OVR      = ovr_q;

endmodule
